// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among N_REQ writeback sources,
// with locked bursts. Define REGFILE_ARB_FWD_EN to add the same-edge write bypass ports.
module regfile_write_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_lock,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [ADDR_W-1:0]          RD,
    output logic [DATA_W-1:0]          WD,
    output logic                       wr_enable,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
`ifdef REGFILE_ARB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = 4;
    // A burst cap of one means a lock can never extend past the first transfer.
    localparam bit LOCK_OK = (MAX_BURST > 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]    owner_reg, owner_next;
    logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [ADDR_W-1:0]  rd_reg;
    logic [DATA_W-1:0]  wd_reg;
    logic               wr_en_reg;
    logic [ID_W-1:0]    grant_id_reg;
    logic               busy_reg;

    logic [ADDR_W-1:0]  addr_arr [N_REQ];
    logic [DATA_W-1:0]  data_arr [N_REQ];

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand_id;
    int                 cand;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        return (i == ID_W'(N_REQ - 1)) ? '0 : i + ID_W'(1);
    endfunction

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_id     = '0;
        if (state_reg == BURST) begin
            grant_found = req_valid[owner_reg];
            grant_idx   = owner_reg;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = int'(rr_ptr_reg) + k;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                cand_id = ID_W'(cand);
                if (req_valid[cand_id]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_id;
                end
            end
        end
        grant_found = grant_found & rst;
    end

    assign req_ready = grant_found ? (N_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            ARB: begin
                if (grant_found) begin
                    if (req_lock[grant_idx] && LOCK_OK) begin
                        state_next     = BURST;
                        owner_next     = grant_idx;
                        burst_cnt_next = CNT_W'(1);
                    end else begin
                        rr_ptr_next = wrap_inc(grant_idx);
                    end
                end
            end
            BURST: begin
                if (!grant_found) begin
                    state_next  = ARB;
                    rr_ptr_next = wrap_inc(owner_reg);
                end else begin
                    burst_cnt_next = burst_cnt_reg + CNT_W'(1);
                    if (!req_lock[owner_reg] || burst_cnt_next == CNT_W'(MAX_BURST)) begin
                        state_next  = ARB;
                        rr_ptr_next = wrap_inc(owner_reg);
                    end
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ARB;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
            rd_reg        <= '0;
            wd_reg        <= '0;
            wr_en_reg     <= 1'b0;
            grant_id_reg  <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
            busy_reg      <= (state_next == BURST);
            wr_en_reg     <= grant_found;
            if (grant_found) begin
                rd_reg       <= addr_arr[grant_idx];
                wd_reg       <= data_arr[grant_idx];
                grant_id_reg <= grant_idx;
            end
        end
    end

    assign RD        = rd_reg;
    assign WD        = wd_reg;
    assign wr_enable = wr_en_reg;
    assign grant_id  = grant_id_reg;
    assign busy      = busy_reg;

`ifdef REGFILE_ARB_FWD_EN
    // Lets decode see a write that lands in the register file on this same edge.
    assign fwd_hit  = wr_en_reg && (fwd_addr == rd_reg);
    assign fwd_data = fwd_hit ? wd_reg : '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued per scenario and
// popped by a write-port monitor; grant/busy sequences are checked inline per cycle.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_lock = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     RD;
    logic [DW-1:0]     WD;
    logic              wr_enable;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef REGFILE_ARB_FWD_EN
    logic [AW-1:0]     fwd_addr = '0;
    logic              fwd_hit;
    logic [DW-1:0]     fwd_data;
`endif

    regfile_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .RD        (RD),
        .WD        (WD),
        .wr_enable (wr_enable),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef REGFILE_ARB_FWD_EN
        ,
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  passes = 0;

    // Per-source stimulus tables: items are presented in order, each held until accepted.
    int          s_cnt [N];
    int          s_idx [N];
    logic [3:0]  s_addr[N][8];
    logic [31:0] s_data[N][8];
    logic        s_lock[N][8];

    always @(negedge clk) begin
        if (rst && wr_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got id=%0d RD=%0d WD=%0d, required no write",
                         grant_id, RD, WD);
            end else begin
                mon_e = exp_q.pop_front();
                if ({grant_id, RD, WD} !== {mon_e.id, mon_e.addr, mon_e.data})
                    $display("FAIL sb_write: got id=%0d RD=%0d WD=%0d, required id=%0d RD=%0d WD=%0d",
                             grant_id, RD, WD, mon_e.id, mon_e.addr, mon_e.data);
                else
                    passes++;
            end
        end
    end

    task automatic push_exp(input int id, input int addr, input int data);
        wr_t e;
        e.id   = 2'(id);
        e.addr = 4'(addr);
        e.data = 32'(data);
        exp_q.push_back(e);
    endtask

    task automatic set_item(input int s, input int k, input int addr, input int data, input logic lock);
        s_addr[s][k] = 4'(addr);
        s_data[s][k] = 32'(data);
        s_lock[s][k] = lock;
        if (k + 1 > s_cnt[s]) s_cnt[s] = k + 1;
    endtask

    task automatic load(input int s);
        if (s_idx[s] < s_cnt[s]) begin
            req_valid[s]          = 1'b1;
            req_lock[s]           = s_lock[s][s_idx[s]];
            req_addr[s*AW +: AW]  = s_addr[s][s_idx[s]];
            req_data[s*DW +: DW]  = s_data[s][s_idx[s]];
        end else begin
            req_valid[s] = 1'b0;
            req_lock[s]  = 1'b0;
        end
    endtask

    task automatic clear_src();
        for (int s = 0; s < N; s++) begin
            s_cnt[s] = 0;
            s_idx[s] = 0;
        end
        req_valid = '0;
        req_lock  = '0;
    endtask

    // Called at a negedge: records accepted transfers, then advances those sources after the edge.
    task automatic step();
        logic [N-1:0] fired;
        fired = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++) begin
            if (fired[s]) begin
                s_idx[s]++;
                load(s);
            end
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_src();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_src();
        set_item(0, 0, 1, 100, 1'b0);
        set_item(1, 0, 2, 200, 1'b0);
        set_item(2, 0, 3, 300, 1'b0);
        push_exp(0, 1, 100);
        push_exp(1, 2, 200);
        push_exp(2, 3, 300);
        for (int s = 0; s < N; s++) load(s);
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, wr_enable, busy} !== 5'b0)
            $display("FAIL reset_ctrl: got ready=%b wr_enable=%b busy=%b, required all 0", req_ready, wr_enable, busy);
        else passes++;
        checks++;
        if ({RD, WD, grant_id} !== '0)
            $display("FAIL reset_data: got RD=%0d WD=%0d id=%0d, required 0", RD, WD, grant_id);
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001)
            $display("FAIL reset_first_grant: got ready=%b, required 001", req_ready);
        else passes++;
        step();
        repeat (4) begin
            @(negedge clk);
            step();
        end
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL reset_drain: got %0d pending writes, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_single_request();
        reset_pulse();
        set_item(1, 0, 3, 99, 1'b0);
        push_exp(1, 3, 99);
        load(1);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010)
            $display("FAIL single_ready: got ready=%b, required 010", req_ready);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if ({wr_enable, RD, WD, grant_id} !== {1'b1, 4'd3, 32'd99, 2'd1})
            $display("FAIL single_write: got we=%b RD=%0d WD=%0d id=%0d, required we=1 RD=3 WD=99 id=1",
                     wr_enable, RD, WD, grant_id);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if ({wr_enable, RD, WD} !== {1'b0, 4'd3, 32'd99})
            $display("FAIL single_idle: got we=%b RD=%0d WD=%0d, required we=0 RD=3 WD=99", wr_enable, RD, WD);
        else passes++;
        step();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] rdy_exp[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        reset_pulse();
        set_item(0, 0, 1, 10, 1'b0);
        set_item(0, 1, 4, 10, 1'b0);
        set_item(1, 0, 2, 20, 1'b0);
        set_item(2, 0, 3, 30, 1'b0);
        push_exp(0, 1, 10);
        push_exp(1, 2, 20);
        push_exp(2, 3, 30);
        push_exp(0, 4, 10);
        for (int s = 0; s < N; s++) load(s);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== rdy_exp[k])
                $display("FAIL rr_grant%0d: got ready=%b, required %b", k, req_ready, rdy_exp[k]);
            else passes++;
            if (k > 0) begin
                checks++;
                if (wr_enable !== 1'b1)
                    $display("FAIL rr_continuous%0d: got wr_enable=%b, required 1", k, wr_enable);
                else passes++;
            end
            step();
        end
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (wr_enable !== 1'b0)
            $display("FAIL rr_idle: got wr_enable=%b, required 0", wr_enable);
        else passes++;
        step();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL rr_drain: got %0d pending writes, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_burst_cap();
        logic [N-1:0] rdy_exp[11] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
                                      3'b010, 3'b100, 3'b100, 3'b000, 3'b000};
        logic         bsy_exp[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                      1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        reset_pulse();
        set_item(1, 0, 5, 50, 1'b0);
        set_item(1, 1, 6, 60, 1'b0);
        set_item(0, 0, 7, 70, 1'b0);
        for (int k = 0; k < 6; k++) set_item(2, k, 8 + k, 1 + k, 1'b1);
        push_exp(1, 5, 50);
        for (int k = 0; k < 4; k++) push_exp(2, 8 + k, 1 + k);
        push_exp(0, 7, 70);
        push_exp(1, 6, 60);
        push_exp(2, 12, 5);
        push_exp(2, 13, 6);
        load(1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, busy} !== {rdy_exp[k], bsy_exp[k]})
                $display("FAIL burst_cycle%0d: got ready=%b busy=%b, required ready=%b busy=%b",
                         k, req_ready, busy, rdy_exp[k], bsy_exp[k]);
            else passes++;
            step();
            if (k == 0) begin
                load(0);
                load(2);
            end
        end
        @(negedge clk);
        step();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL burst_drain: got %0d pending writes, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_burst_abort_reset();
        logic [N-1:0] rdy_exp[4] = '{3'b001, 3'b001, 3'b000, 3'b010};
        logic         bsy_exp[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        reset_pulse();
        set_item(0, 0, 1, 32'hA1, 1'b1);
        set_item(0, 1, 2, 32'hA2, 1'b1);
        set_item(1, 0, 3, 32'hB1, 1'b0);
        push_exp(0, 1, 32'hA1);
        push_exp(0, 2, 32'hA2);
        load(0);
        load(1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, busy} !== {rdy_exp[k], bsy_exp[k]})
                $display("FAIL abort_cycle%0d: got ready=%b busy=%b, required ready=%b busy=%b",
                         k, req_ready, busy, rdy_exp[k], bsy_exp[k]);
            else passes++;
            step();
        end
        #2;
        checks++;
        if ({wr_enable, RD, WD, grant_id} !== {1'b1, 4'd3, 32'hB1, 2'd1})
            $display("FAIL abort_write: got we=%b RD=%0d WD=%h id=%0d, required we=1 RD=3 WD=b1 id=1",
                     wr_enable, RD, WD, grant_id);
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if ({wr_enable, RD, WD} !== {1'b0, 4'd0, 32'd0})
            $display("FAIL async_reset: got we=%b RD=%0d WD=%0d, required all 0 before clk edge", wr_enable, RD, WD);
        else passes++;
        clear_src();
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL abort_drain: got %0d pending writes, required 0", exp_q.size());
        else passes++;
    endtask

`ifdef REGFILE_ARB_FWD_EN
    task automatic test_forward();
        reset_pulse();
        set_item(0, 0, 5, 255, 1'b0);
        push_exp(0, 5, 255);
        load(0);
        @(negedge clk);
        step();
        fwd_addr = 4'd5;
        #1;
        checks++;
        if ({fwd_hit, fwd_data} !== {1'b1, 32'd255})
            $display("FAIL fwd_hit: got hit=%b data=%0d, required hit=1 data=255", fwd_hit, fwd_data);
        else passes++;
        fwd_addr = 4'd4;
        #1;
        checks++;
        if ({fwd_hit, fwd_data} !== {1'b0, 32'd0})
            $display("FAIL fwd_miss: got hit=%b data=%0d, required hit=0 data=0", fwd_hit, fwd_data);
        else passes++;
        @(negedge clk);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_request();
        test_round_robin();
        test_burst_cap();
        test_burst_abort_reset();
`ifdef REGFILE_ARB_FWD_EN
        test_forward();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
